// File: rtl/ft60x_fifo_port_pkg.sv
// ft60x_fifo_port_pkg: FSM encoding, 245-mode pin defaults and RX buffer sizing shared by the FT60x port
package ft60x_fifo_port_pkg;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RX_OE    = 3'd1;
  localparam logic [2:0] ST_RX_READ  = 3'd2;
  localparam logic [2:0] ST_RX_END   = 3'd3;
  localparam logic [2:0] ST_TX_WRITE = 3'd4;
  localparam logic PIN_IDLE = 1'b1;
  localparam int RX_DEPTH_DEF    = 8;
  localparam int RX_HEADROOM_DEF = 3;
  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } rx_word_t;
endpackage

// File: rtl/ft60x_fifo_port_if.sv
// ft60x_fifo_port_if: FT60x pad signals plus the RX/TX word streams of the port controller
interface ft60x_fifo_port_if;
  logic        ftdi_rxf_i;
  logic        ftdi_txe_i;
  logic [31:0] ftdi_data_in_i;
  logic [3:0]  ftdi_be_in_i;
  logic        ftdi_rdn_o;
  logic        ftdi_wrn_o;
  logic        ftdi_oen_o;
  logic [31:0] ftdi_data_out_o;
  logic [3:0]  ftdi_be_out_o;
  logic        outport_valid_o;
  logic        outport_ready_i;
  logic [31:0] outport_data_o;
  logic [3:0]  outport_strb_o;
  logic        inport_valid_i;
  logic        inport_ready_o;
  logic [31:0] inport_data_i;
  logic [3:0]  inport_strb_i;
  modport master (
    input  ftdi_rxf_i, ftdi_txe_i, ftdi_data_in_i, ftdi_be_in_i,
    input  outport_ready_i, inport_valid_i, inport_data_i, inport_strb_i,
    output ftdi_rdn_o, ftdi_wrn_o, ftdi_oen_o, ftdi_data_out_o, ftdi_be_out_o,
    output outport_valid_o, outport_data_o, outport_strb_o, inport_ready_o
  );
  modport slave (
    output ftdi_rxf_i, ftdi_txe_i, ftdi_data_in_i, ftdi_be_in_i,
    output outport_ready_i, inport_valid_i, inport_data_i, inport_strb_i,
    input  ftdi_rdn_o, ftdi_wrn_o, ftdi_oen_o, ftdi_data_out_o, ftdi_be_out_o,
    input  outport_valid_o, outport_data_o, outport_strb_o, inport_ready_o
  );
endinterface

// File: rtl/ft60x_rx_fifo.sv
// ft60x_rx_fifo: synchronous word+byte-enable FIFO buffering FT60x read data, with fill level
module ft60x_rx_fifo
  import ft60x_fifo_port_pkg::*;
#(
  parameter int DEPTH = RX_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push,
  input  rx_word_t               push_word,
  input  logic                   pop,
  output logic                   valid,
  output rx_word_t               head,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  rx_word_t mem [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign level = wr_q - rd_q;
  assign valid = level != '0;
  assign head  = mem[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (push) mem[wr_q[AW-1:0]] <= push_word;
  // The controller's headroom rule must make a push into a full buffer impossible
  always_ff @(posedge clk_i)
    if (!rst_i) assert (!(push && !pop && level == (AW+1)'(DEPTH)));
endmodule

// File: rtl/ft60x_fifo_port.sv
// ft60x_fifo_port: FT60x 245-mode synchronous FIFO pin controller bridging pads to RX/TX word streams
module ft60x_fifo_port
  import ft60x_fifo_port_pkg::*;
#(
  parameter int RX_DEPTH    = RX_DEPTH_DEF,
  parameter int RX_HEADROOM = RX_HEADROOM_DEF
) (
  input logic               clk_i,
  input logic               rst_i,
  ft60x_fifo_port_if.master bus
);
  localparam int LW = $clog2(RX_DEPTH) + 1;
  logic [2:0]    state;
  logic          rdn_q, wrn_q, oen_q, last_rx_q;
  logic [31:0]   data_out_q;
  logic [3:0]    be_out_q;
  logic [LW-1:0] level, free, free_next;
  logic          push, pop, rx_valid, rx_cand, tx_cand, rx_leave, tx_hs, tx_acc;
  rx_word_t      in_word, head;
  assign in_word   = {bus.ftdi_be_in_i, bus.ftdi_data_in_i};
  assign push      = !rdn_q && !bus.ftdi_rxf_i;
  assign pop       = rx_valid && bus.outport_ready_i;
  assign free      = LW'(RX_DEPTH) - level;
  assign free_next = free - LW'(push) + LW'(pop);
  assign rx_cand   = !bus.ftdi_rxf_i && free >= LW'(RX_HEADROOM);
  assign tx_cand   = !bus.ftdi_txe_i && bus.inport_valid_i;
  // Stop reading once the word landing this edge would leave one slot or less
  assign rx_leave  = bus.ftdi_rxf_i || free_next <= LW'(1);
  assign tx_acc    = !wrn_q && !bus.ftdi_txe_i;
  assign tx_hs     = bus.inport_valid_i && bus.inport_ready_o;
  assign bus.inport_ready_o  = state == ST_TX_WRITE && (wrn_q || !bus.ftdi_txe_i);
  assign bus.ftdi_rdn_o      = rdn_q;
  assign bus.ftdi_wrn_o      = wrn_q;
  assign bus.ftdi_oen_o      = oen_q;
  assign bus.ftdi_data_out_o = data_out_q;
  assign bus.ftdi_be_out_o   = be_out_q;
  assign bus.outport_valid_o = rx_valid;
  assign bus.outport_data_o  = head.data;
  assign bus.outport_strb_o  = head.be;
  ft60x_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_word (in_word),
    .pop       (pop),
    .valid     (rx_valid),
    .head      (head),
    .level     (level)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      rdn_q      <= PIN_IDLE;
      wrn_q      <= PIN_IDLE;
      oen_q      <= PIN_IDLE;
      data_out_q <= '0;
      be_out_q   <= '0;
      last_rx_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (rx_cand && (!tx_cand || !last_rx_q)) begin
            state     <= ST_RX_OE;
            oen_q     <= 1'b0;
            last_rx_q <= 1'b1;
          end else if (tx_cand) begin
            state     <= ST_TX_WRITE;
            last_rx_q <= 1'b0;
          end
        ST_RX_OE: begin
          state <= ST_RX_READ;
          rdn_q <= 1'b0;
        end
        ST_RX_READ:
          if (rx_leave) begin
            state <= ST_RX_END;
            rdn_q <= 1'b1;
          end
        ST_RX_END: begin
          state <= ST_IDLE;
          oen_q <= 1'b1;
        end
        ST_TX_WRITE:
          if (tx_hs) begin
            data_out_q <= bus.inport_data_i;
            be_out_q   <= bus.inport_strb_i;
            wrn_q      <= 1'b0;
          end else if (tx_acc || (wrn_q && !bus.inport_valid_i)) begin
            wrn_q <= 1'b1;
            state <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ft60x_fifo_port.sv
// tb_ft60x_fifo_port: FT60x host/stream models with word scoreboards checking the FIFO port controller
module tb_ft60x_fifo_port;
  logic clk, rst;
  int compared, mismatched;
  logic [35:0] host_q[$], rx_exp[$], rx_got[$], tx_src[$], tx_exp[$], tx_got[$];
  bit bursts[$];
  bit rx_take, in_take, rx_gap, tx_gap, txe_ok;
  bit prev_oen, prev2_oen, prev_rdn, prev_wrn;
  int rx_cnt, tx_cnt, rx_chunk, tx_chunk, ready_mode, overlap, rd_seq_bad;

  ft60x_fifo_port_if bus();
  ft60x_fifo_port #(.RX_DEPTH(8), .RX_HEADROOM(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad-side FT60x model and stream endpoints; everything moves at negedge, transfers commit at posedge
  initial begin
    bus.ftdi_rxf_i = 1; bus.ftdi_txe_i = 1; bus.ftdi_data_in_i = 0; bus.ftdi_be_in_i = 0;
    bus.inport_valid_i = 0; bus.inport_data_i = 0; bus.inport_strb_i = 0; bus.outport_ready_i = 0;
    rx_take = 0; in_take = 0; rx_gap = 0; tx_gap = 0;
    prev_oen = 1; prev2_oen = 1; prev_rdn = 1; prev_wrn = 1;
    forever begin
      @(negedge clk);
      if (rx_take && host_q.size() > 0) begin
        host_q.delete(0); rx_cnt++; rx_gap = rx_chunk != 0 && rx_cnt % rx_chunk == 0;
      end else rx_gap = 0;
      if (in_take && tx_src.size() > 0) begin
        tx_src.delete(0); tx_cnt++; tx_gap = tx_chunk != 0 && tx_cnt % tx_chunk == 0;
      end else tx_gap = 0;
      bus.ftdi_rxf_i = host_q.size() == 0 || rx_gap;
      if (host_q.size() > 0) {bus.ftdi_be_in_i, bus.ftdi_data_in_i} = host_q[0];
      else {bus.ftdi_be_in_i, bus.ftdi_data_in_i} = {4'($urandom()), 32'($urandom())};
      bus.ftdi_txe_i = !txe_ok;
      bus.inport_valid_i = tx_src.size() > 0 && !tx_gap;
      if (tx_src.size() > 0) {bus.inport_strb_i, bus.inport_data_i} = tx_src[0];
      bus.outport_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      rx_take = !rst && !bus.ftdi_rdn_o && !bus.ftdi_rxf_i;
      in_take = !rst && bus.inport_valid_i && bus.inport_ready_o;
      if (!rst && bus.outport_valid_o && bus.outport_ready_i) rx_got.push_back({bus.outport_strb_o, bus.outport_data_o});
      if (!rst && !bus.ftdi_wrn_o && !bus.ftdi_txe_i) tx_got.push_back({bus.ftdi_be_out_o, bus.ftdi_data_out_o});
      if (!bus.ftdi_oen_o && !bus.ftdi_wrn_o) overlap++;
      if (prev_oen && !bus.ftdi_oen_o) bursts.push_back(1'b1);
      if (prev_wrn && !bus.ftdi_wrn_o) bursts.push_back(1'b0);
      if (prev_rdn && !bus.ftdi_rdn_o && !(!prev_oen && prev2_oen)) rd_seq_bad++;
      prev2_oen = prev_oen; prev_oen = bus.ftdi_oen_o; prev_rdn = bus.ftdi_rdn_o; prev_wrn = bus.ftdi_wrn_o;
    end
  end

  task automatic test_reset;
    @(negedge clk); #2;
    ready_mode = 1; rx_got.delete();
    for (int i = 0; i < 10; i++) host_q.push_back({4'hF, 32'($urandom())});
    for (int i = 0; i < 50 && bus.ftdi_rdn_o !== 1'b0; i++) @(negedge clk);
    compared++; if (bus.ftdi_rdn_o !== 1'b0) begin mismatched++; $display("FAIL reset_burst_active: rdn=%b want 0", bus.ftdi_rdn_o); end
    rst = 1;
    @(negedge clk);
    compared++; if (bus.ftdi_rdn_o !== 1'b1) begin mismatched++; $display("FAIL reset_rdn: got %b want 1", bus.ftdi_rdn_o); end
    compared++; if (bus.ftdi_wrn_o !== 1'b1) begin mismatched++; $display("FAIL reset_wrn: got %b want 1", bus.ftdi_wrn_o); end
    compared++; if (bus.ftdi_oen_o !== 1'b1) begin mismatched++; $display("FAIL reset_oen: got %b want 1", bus.ftdi_oen_o); end
    compared++; if (bus.outport_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", bus.outport_valid_o); end
    compared++; if (bus.inport_ready_o !== 1'b0) begin mismatched++; $display("FAIL reset_ready: got %b want 0", bus.inport_ready_o); end
    compared++; if ({bus.ftdi_be_out_o, bus.ftdi_data_out_o} !== 36'h0) begin mismatched++; $display("FAIL reset_data_out: got %h want 0", {bus.ftdi_be_out_o, bus.ftdi_data_out_o}); end
    #2; host_q.delete();
    @(negedge clk); #2;
    rx_got.delete(); rst = 0; ready_mode = 0;
    repeat (3) @(negedge clk);
    compared++; if (bus.ftdi_oen_o !== 1'b1 || rx_got.size() != 0) begin mismatched++; $display("FAIL reset_after: oen=%b words=%0d want 1/0", bus.ftdi_oen_o, rx_got.size()); end
  endtask

  task automatic test_rx_burst;
    @(negedge clk); #2;
    rx_got.delete(); rd_seq_bad = 0; ready_mode = 0;
    for (int i = 1; i <= 5; i++) host_q.push_back({4'hF, 32'(32'h11111111 * i)});
    rx_exp = host_q;
    for (int i = 0; i < 200 && rx_got.size() < 5; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    compared++; if (rx_got.size() != 5) begin mismatched++; $display("FAIL rx_burst_count: got %0d want 5", rx_got.size()); end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (i >= rx_got.size() || rx_got[i] !== rx_exp[i]) begin mismatched++; $display("FAIL rx_burst_word%0d: got %h want %h", i, i < rx_got.size() ? rx_got[i] : 36'h0, rx_exp[i]); end
    end
    compared++; if (rd_seq_bad != 0) begin mismatched++; $display("FAIL rx_oe_before_rd: bad=%0d want 0", rd_seq_bad); end
    compared++; if (bus.ftdi_oen_o !== 1'b1) begin mismatched++; $display("FAIL rx_burst_end_oen: got %b want 1", bus.ftdi_oen_o); end
  endtask

  task automatic test_rx_backpressure;
    @(negedge clk); #2;
    rx_got.delete(); ready_mode = 1;
    for (int i = 0; i < 20; i++) host_q.push_back({4'($urandom_range(1, 15)), 32'($urandom())});
    rx_exp = host_q;
    repeat (40) @(negedge clk);
    compared++; if (host_q.size() != 13) begin mismatched++; $display("FAIL bp_pause_taken: got %0d remaining want 13", host_q.size()); end
    compared++; if (bus.ftdi_rdn_o !== 1'b1 || bus.ftdi_oen_o !== 1'b1) begin mismatched++; $display("FAIL bp_pause_pins: rdn=%b oen=%b want 1/1", bus.ftdi_rdn_o, bus.ftdi_oen_o); end
    compared++; if (bus.outport_valid_o !== 1'b1) begin mismatched++; $display("FAIL bp_valid: got %b want 1", bus.outport_valid_o); end
    ready_mode = 2;
    for (int i = 0; i < 2000 && rx_got.size() < 20; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    compared++; if (rx_got.size() != 20) begin mismatched++; $display("FAIL bp_count: got %0d want 20", rx_got.size()); end
    for (int i = 0; i < 20; i++) begin
      compared++;
      if (i >= rx_got.size() || rx_got[i] !== rx_exp[i]) begin mismatched++; $display("FAIL bp_word%0d: got %h want %h", i, i < rx_got.size() ? rx_got[i] : 36'h0, rx_exp[i]); end
    end
    ready_mode = 0;
  endtask

  task automatic test_tx_throttle;
    logic [35:0] w;
    @(negedge clk); #2;
    tx_got.delete(); txe_ok = 1;
    for (int i = 0; i < 8; i++) tx_src.push_back({4'hF, 32'(32'hA0000000 + i)});
    tx_exp = tx_src;
    for (int i = 0; i < 100 && tx_got.size() < 3; i++) @(negedge clk);
    txe_ok = 0;
    repeat (2) @(negedge clk); #2;
    w = tx_exp[tx_got.size()];
    compared++; if (bus.ftdi_wrn_o !== 1'b0) begin mismatched++; $display("FAIL tx_hold_wrn: got %b want 0", bus.ftdi_wrn_o); end
    compared++; if (bus.ftdi_data_out_o !== w[31:0]) begin mismatched++; $display("FAIL tx_hold_data: got %h want %h", bus.ftdi_data_out_o, w[31:0]); end
    compared++; if (bus.inport_ready_o !== 1'b0) begin mismatched++; $display("FAIL tx_hold_ready: got %b want 0", bus.inport_ready_o); end
    @(negedge clk);
    txe_ok = 1;
    for (int i = 0; i < 200 && tx_got.size() < 8; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    compared++; if (tx_got.size() != 8) begin mismatched++; $display("FAIL tx_count: got %0d want 8", tx_got.size()); end
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (i >= tx_got.size() || tx_got[i] !== tx_exp[i]) begin mismatched++; $display("FAIL tx_word%0d: got %h want %h", i, i < tx_got.size() ? tx_got[i] : 36'h0, tx_exp[i]); end
    end
  endtask

  task automatic test_partial;
    logic [35:0] r;
    @(negedge clk); #2;
    tx_got.delete(); rx_got.delete();
    r = {4'h3, 32'($urandom())};
    tx_src.push_back({4'h1, 32'h000000AB});
    host_q.push_back(r);
    for (int i = 0; i < 100 && (tx_got.size() < 1 || rx_got.size() < 1); i++) @(negedge clk);
    compared++; if (tx_got.size() != 1 || tx_got[0] !== {4'h1, 32'h000000AB}) begin mismatched++; $display("FAIL partial_tx: got %h (n=%0d) want 1000000ab", tx_got.size() > 0 ? tx_got[0] : 36'h0, tx_got.size()); end
    compared++; if (rx_got.size() != 1 || rx_got[0] !== r) begin mismatched++; $display("FAIL partial_rx: got %h (n=%0d) want %h", rx_got.size() > 0 ? rx_got[0] : 36'h0, rx_got.size(), r); end
  endtask

  task automatic test_arbitration;
    @(negedge clk);
    rst = 1;
    @(negedge clk); #2;
    rx_got.delete(); tx_got.delete(); bursts.delete(); overlap = 0; rd_seq_bad = 0;
    rx_cnt = 0; tx_cnt = 0; rx_chunk = 3; tx_chunk = 3; ready_mode = 0; txe_ok = 1;
    for (int i = 0; i < 12; i++) host_q.push_back({4'hF, 32'($urandom())});
    for (int i = 0; i < 12; i++) tx_src.push_back({4'hF, 32'($urandom())});
    rx_exp = host_q; tx_exp = tx_src;
    rst = 0;
    for (int i = 0; i < 1000 && (rx_got.size() < 12 || tx_got.size() < 12); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    compared++; if (bursts.size() != 8) begin mismatched++; $display("FAIL arb_burst_count: got %0d want 8", bursts.size()); end
    for (int i = 0; i < bursts.size() && i < 8; i++) begin
      compared++; if (bursts[i] != (i % 2 == 0)) begin mismatched++; $display("FAIL arb_order%0d: got rx=%0d want rx=%0d", i, bursts[i], i % 2 == 0); end
    end
    compared++; if (overlap != 0) begin mismatched++; $display("FAIL arb_oe_wr_overlap: got %0d cycles want 0", overlap); end
    compared++; if (rd_seq_bad != 0) begin mismatched++; $display("FAIL arb_oe_before_rd: bad=%0d want 0", rd_seq_bad); end
    for (int i = 0; i < 12; i++) begin
      compared++;
      if (i >= rx_got.size() || rx_got[i] !== rx_exp[i]) begin mismatched++; $display("FAIL arb_rx%0d: got %h want %h", i, i < rx_got.size() ? rx_got[i] : 36'h0, rx_exp[i]); end
      compared++;
      if (i >= tx_got.size() || tx_got[i] !== tx_exp[i]) begin mismatched++; $display("FAIL arb_tx%0d: got %h want %h", i, i < tx_got.size() ? tx_got[i] : 36'h0, tx_exp[i]); end
    end
    rx_chunk = 0; tx_chunk = 0;
  endtask

  initial begin
    rst = 1; compared = 0; mismatched = 0; txe_ok = 0; ready_mode = 0;
    rx_cnt = 0; tx_cnt = 0; rx_chunk = 0; tx_chunk = 0; overlap = 0; rd_seq_bad = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    test_reset;
    test_rx_burst;
    test_rx_backpressure;
    test_tx_throttle;
    test_partial;
    test_arbitration;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ft60x_fifo_port.md
# ft60x_fifo_port

Synchronous-FIFO (245 mode) pin controller for the FT600/FT601 USB3 bridge, running entirely in the FTDI clock domain. It sits directly between the FT60x pad wiring (32-bit data, 4-bit byte enables, RXF#/TXE#/RD#/WR#/OE#) and the rest of the SoC. On the SoC side it presents two valid/ready word streams: host-to-FPGA (RX) and FPGA-to-host (TX). It arbitrates bus direction, sequences the OE#/RD# turnaround, buffers in-flight read data in a small FIFO, and never drops or duplicates a word.

## Interface
- RX_DEPTH, 8: RX buffer depth in words (power of 2, ≥4).
- RX_HEADROOM, 3: free RX entries required before a read burst starts.
- clk_i  in  1  FTDI clock (ftdi_clk pad, 100 MHz).
- rst_i  in  1  synchronous, active-high reset.
- ftdi_rxf_i  in  1  RXF#, active low: host data available.
- ftdi_txe_i  in  1  TXE#, active low: FT60x TX FIFO has space.
- ftdi_data_in_i  in  32  data bus sampled from pads.
- ftdi_be_in_i  in  4  byte enables sampled from pads.
- ftdi_rdn_o  out  1  RD#, registered.
- ftdi_wrn_o  out  1  WR#, registered.
- ftdi_oen_o  out  1  OE#, registered; pads driven by FPGA whenever this is 1.
- ftdi_data_out_o  out  32  registered write data.
- ftdi_be_out_o  out  4  registered write byte enables.
- outport_valid_o / outport_ready_i  out/in  1  RX stream handshake.
- outport_data_o / outport_strb_o  out  32/4  RX word and byte enables (FIFO head).
- inport_valid_i / inport_ready_o  in/out  1  TX stream handshake.
- inport_data_i / inport_strb_i  in  32/4  TX word and byte enables.

## Operation
- States: IDLE, RX_OE, RX_READ, RX_END, TX_WRITE.
- IDLE: rdn=wrn=oen=1. Candidates: RX if !ftdi_rxf_i and free ≥ RX_HEADROOM; TX if !ftdi_txe_i and inport_valid_i. Both → alternate (last_rx_q flag; reset favours RX).
- RX_OE: oen=0 for exactly one cycle (bus turnaround), then RX_READ.
- RX_READ: oen=0, rdn=0. Word captured into RX FIFO on every edge where rdn_q==0 and ftdi_rxf_i==0. Leave (rdn→1) when ftdi_rxf_i==1 or free ≤ 1 after this cycle's push; go RX_END.
- RX_END: oen=0, rdn=1 one cycle (data still owned by FT60x; a word sampled here with rxf low is NOT captured), then oen=1, IDLE.
- TX_WRITE: oen=1. Output register holds a pending word with wrn_q=0. Pending word is accepted on an edge where wrn_q==0 and ftdi_txe_i==0. inport_ready_o = state==TX_WRITE && (wrn_q==1 || !ftdi_txe_i) (combinational). On inport handshake load data/be, wrn_q=0; on acceptance without a new word, wrn_q=1 and go IDLE. If txe high while wrn_q=0, hold word and wrn_q=0 until accepted.
- RX FIFO: push from pads, pop on outport_valid_o && outport_ready_i; simultaneous push/pop keeps level. Never overflows by construction; overflow is an assertion failure.
- Byte enables pass through unmodified both ways (partial last word).

## Timing
- Reset: state IDLE, rdn/wrn/oen=1, data_out/be_out=0, FIFO empty, outport_valid_o=0, inport_ready_o=0, last_rx_q=0.
- rst_i mid-burst: all pin outputs return to 1 on the next edge; RX FIFO contents discarded; pending TX word lost.
- RX latency: word on pads at capture edge N → outport_valid_o at N+1.
- Burst start: RXF# low at edge N in IDLE → OE# low after N+1, RD# low after N+2.
- TX: inport handshake at edge N → WR# low with data after N; sustained one word/cycle while TXE# low and stream valid.
- Minimum one IDLE cycle between any two bursts.

## Structure
- Shared package: state encoding constant, FT60x 245-mode pin defaults (all-high idle), RX_DEPTH/RX_HEADROOM defaults.
- One sub-module: ft60x_rx_fifo (synchronous FIFO, 36-bit wide, level output for free-space check).

## Test plan
- Reset: hold rst_i 3 cycles during active RX burst → rdn/wrn/oen=1, outport_valid_o=0 next cycle.
- RX burst: model asserts RXF# with 5 words 0x11111111..0x55555555, BE=0xF, ready=1 → OE# low one cycle before RD#, exactly 5 words out in order, no duplicate from RX_END.
- RX backpressure: outport_ready_i=0, host offers 20 words → read pauses at free≤1, resumes after drain, all 20 delivered in order.
- TX with TXE# throttle: send 0xA0000000..0xA0000007, deassert TXE# for 3 cycles mid-burst → held word retained, model receives 8 words once each.
- Partial word: TX word 0x000000AB with strb 0x1 → ftdi_be_out_o=0x1 at acceptance; RX BE=0x3 passes to outport_strb_o=0x3.
- Arbitration: RXF# and TXE# low with inport_valid continuously → bursts alternate RX/TX, starting with RX after reset; no OE#-low cycle coincides with WR# low.
